voice_mix_scheduler: RTL and testbench

- Time-multiplexes one shared voice-sample lookup datapath (phase step + sine ROM) across NUM_VOICES chord voices, once per sample request.
- Sums the returned per-voice samples, scales and saturates the sum, and hands one mixed 16-bit sample downstream with a one-cycle ready strobe.
- Sits between the codec conditioner's generate_next_sample request and the echo / codec sample path, in place of per-voice private lookup hardware.

---
 rtl/voice_mix_scheduler.sv | 171 +++++++++++++++++
 tb/tb_voice_mix_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_scheduler.sv
// Shares one phase-step/sine lookup datapath across NUM_VOICES chord voices per sample request,
// accumulating the returned samples into one scaled, saturated 16-bit mixed sample.
module voice_mix_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int VIDX_W     = 2,
   parameter int MIX_SHIFT  = 2,
   parameter int TIMEOUT    = 15,
   parameter int TO_W       = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     generate_next_sample,
   input  logic                     play_enable,
   input  logic [NUM_VOICES-1:0]    voice_active,
   output logic                     lookup_req,
   output logic [VIDX_W-1:0]        lookup_voice,
   input  logic                     lookup_valid,
   input  logic signed [15:0]       lookup_sample,
   output logic signed [15:0]       sample_out,
   output logic                     new_sample_ready,
   output logic                     overrun,
   output logic                     lookup_fault
);

   localparam int ACC_W = 16 + VIDX_W + 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
   localparam logic [VIDX_W-1:0]       LAST_IDX = VIDX_W'(NUM_VOICES - 1);
   localparam logic [TO_W-1:0]         TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                   state_r, state_s;
   logic [VIDX_W-1:0]        idx_r, idx_s;
   logic signed [ACC_W-1:0]  acc_r, acc_s;
   logic [TO_W-1:0]          to_cnt_r, to_cnt_s;
   logic                     lookup_req_r, lookup_req_s;
   logic [VIDX_W-1:0]        lookup_voice_r, lookup_voice_s;
   logic signed [15:0]       sample_out_r, sample_out_s;
   logic                     new_sample_ready_r, new_sample_ready_s;
   logic                     overrun_r, overrun_s;
   logic                     lookup_fault_r, lookup_fault_s;
   logic                     voice_live_s;
   logic                     last_voice_s;
   logic signed [ACC_W-1:0]  acc_shifted_s;
   logic signed [ACC_W-1:0]  sample_ext_s;

   function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return 16'sh7FFF;
      end else if (v < SAT_MIN) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

   assign voice_live_s  = voice_active[idx_r] & play_enable;
   assign last_voice_s  = (idx_r == LAST_IDX);
   assign acc_shifted_s = acc_r >>> MIX_SHIFT;
   assign sample_ext_s  = {{(ACC_W-16){lookup_sample[15]}}, lookup_sample};

   // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
   always_comb begin
      state_s            = state_r;
      idx_s              = idx_r;
      acc_s              = acc_r;
      to_cnt_s           = to_cnt_r;
      lookup_req_s       = 1'b0;
      lookup_voice_s     = lookup_voice_r;
      sample_out_s       = sample_out_r;
      new_sample_ready_s = 1'b0;
      overrun_s          = overrun_r | (generate_next_sample & (state_r != IDLE));
      lookup_fault_s     = lookup_fault_r;
      case (state_r)
         IDLE: begin
            if (generate_next_sample) begin
               acc_s   = '0;
               idx_s   = '0;
               state_s = SCAN;
            end else begin
               state_s = IDLE;
            end
         end
         SCAN: begin
            if (voice_live_s) begin
               lookup_req_s   = 1'b1;
               lookup_voice_s = idx_r;
               state_s        = ISSUE;
            end else if (last_voice_s) begin
               state_s = DONE;
            end else begin
               idx_s   = idx_r + VIDX_W'(1);
               state_s = SCAN;
            end
         end
         ISSUE: begin
            to_cnt_s = '0;
            state_s  = WAIT;
         end
         WAIT: begin
            // A result landing on the final timeout cycle still counts as a valid answer.
            if (lookup_valid || (to_cnt_r == TO_LAST)) begin
               if (lookup_valid) begin
                  acc_s = acc_r + sample_ext_s;
               end else begin
                  lookup_fault_s = 1'b1;
               end
               if (last_voice_s) begin
                  state_s = DONE;
               end else begin
                  idx_s   = idx_r + VIDX_W'(1);
                  state_s = SCAN;
               end
            end else begin
               to_cnt_s = to_cnt_r + TO_W'(1);
               state_s  = WAIT;
            end
         end
         DONE: begin
            sample_out_s       = sat16(acc_shifted_s);
            new_sample_ready_s = 1'b1;
            state_s            = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r            <= IDLE;
         idx_r              <= '0;
         acc_r              <= '0;
         to_cnt_r           <= '0;
         lookup_req_r       <= 1'b0;
         lookup_voice_r     <= '0;
         sample_out_r       <= 16'sd0;
         new_sample_ready_r <= 1'b0;
         overrun_r          <= 1'b0;
         lookup_fault_r     <= 1'b0;
      end else begin
         state_r            <= state_s;
         idx_r              <= idx_s;
         acc_r              <= acc_s;
         to_cnt_r           <= to_cnt_s;
         lookup_req_r       <= lookup_req_s;
         lookup_voice_r     <= lookup_voice_s;
         sample_out_r       <= sample_out_s;
         new_sample_ready_r <= new_sample_ready_s;
         overrun_r          <= overrun_s;
         lookup_fault_r     <= lookup_fault_s;
      end
   end

   assign lookup_req       = lookup_req_r;
   assign lookup_voice     = lookup_voice_r;
   assign sample_out       = sample_out_r;
   assign new_sample_ready = new_sample_ready_r;
   assign overrun          = overrun_r;
   assign lookup_fault     = lookup_fault_r;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench: three schedulers (MIX_SHIFT 0,1,2) share stimulus; a bench-side
// datapath answers each lookup_req one cycle later with a per-voice programmed sample.
module tb_voice_mix_scheduler;

   logic               clk;
   logic               reset;
   logic               gen;
   logic               play_enable;
   logic [3:0]         voice_active;
   logic               lookup_valid;
   logic signed [15:0] lookup_sample;

   logic               lreq   [3];
   logic [1:0]         lvoice [3];
   logic signed [15:0] sout   [3];
   logic               rdy    [3];
   logic               ovr    [3];
   logic               flt    [3];

   int checks;
   int failures;

   logic signed [15:0] resp_val [4];
   logic               resp_en  [4];
   int                 nreq;
   logic [15:0]        vlist;
   int                 rdy_cyc;
   int                 pulses;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      voice_mix_scheduler #(
         .NUM_VOICES(4), .VIDX_W(2), .MIX_SHIFT(g), .TIMEOUT(15), .TO_W(4)
      ) u_dut (
         .clk                 (clk),
         .reset               (reset),
         .generate_next_sample(gen),
         .play_enable         (play_enable),
         .voice_active        (voice_active),
         .lookup_req          (lreq[g]),
         .lookup_voice        (lvoice[g]),
         .lookup_valid        (lookup_valid),
         .lookup_sample       (lookup_sample),
         .sample_out          (sout[g]),
         .new_sample_ready    (rdy[g]),
         .overrun             (ovr[g]),
         .lookup_fault        (flt[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Issue one request (edge after the first negedge) and serve lookups until ready + 3 cycles.
   // cyc counts negedges after the request edge; extra>0 re-asserts the request at that negedge.
   task automatic run_seq(input logic [3:0] act, input logic pe, input int extra);
      int  cyc;
      logic pend;
      logic [1:0] pv;
      voice_active = act;
      play_enable  = pe;
      pend = 1'b0;
      pv   = 2'd0;
      @(negedge clk) gen = 1'b1;
      @(negedge clk) gen = 1'b0;
      cyc = 1; nreq = 0; vlist = 16'h0000; rdy_cyc = 0; pulses = 0;
      while ((cyc < 80) && !((rdy_cyc != 0) && (cyc >= rdy_cyc + 3))) begin
         lookup_valid  = 1'b0;
         lookup_sample = 16'sd0;
         if (pend) begin
            lookup_valid  = resp_en[pv];
            lookup_sample = resp_val[pv];
            pend = 1'b0;
         end
         if (lreq[2]) begin
            nreq++;
            vlist = {vlist[13:0], lvoice[2]};
            pv    = lvoice[2];
            pend  = 1'b1;
         end
         if (rdy[2]) begin
            pulses++;
            if (rdy_cyc == 0) rdy_cyc = cyc;
         end
         gen = (cyc == extra);
         @(negedge clk);
         cyc++;
      end
      lookup_valid = 1'b0;
      gen = 1'b0;
   endtask

   task automatic set_resp(input logic [3:0] en, input logic signed [15:0] v0, input logic signed [15:0] v1,
                           input logic signed [15:0] v2, input logic signed [15:0] v3);
      for (int i = 0; i < 4; i++) resp_en[i] = en[i];
      resp_val[0] = v0; resp_val[1] = v1; resp_val[2] = v2; resp_val[3] = v3;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; gen = 1'b0; play_enable = 1'b1; voice_active = 4'b0000;
      lookup_valid = 1'b0; lookup_sample = 16'sd0;
      set_resp(4'b0000, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req",   32'(lreq[2]),   32'd0);
      chk("rst_voice", 32'(lvoice[2]), 32'd0);
      chk("rst_out",   32'(sout[2]),   32'd0);
      chk("rst_rdy",   32'(rdy[2]),    32'd0);
      chk("rst_ovr",   32'(ovr[2]),    32'd0);
      chk("rst_flt",   32'(flt[2]),    32'd0);

      // No active voices: no lookups, ready at cycle 6, zero output.
      run_seq(4'b0000, 1'b1, 0);
      chk("idle_nreq",   nreq,    0);
      chk("idle_rdycyc", rdy_cyc, 6);
      chk("idle_pulses", pulses,  1);
      chk("idle_out",    32'(sout[2]), 32'd0);

      // All four voices answer 8000: sum 32000.
      set_resp(4'b1111, 16'sd8000, 16'sd8000, 16'sd8000, 16'sd8000);
      run_seq(4'b1111, 1'b1, 0);
      chk("all_vlist",  32'(vlist), 32'h001B);
      chk("all_nreq",   nreq,    4);
      chk("all_rdycyc", rdy_cyc, 14);
      chk("all_out_s2", 32'(sout[2]), 32'd8000);
      chk("all_out_s1", 32'(sout[1]), 32'd16000);
      chk("all_out_s0", 32'(sout[0]), 32'd32000);

      // play_enable low masks every voice.
      run_seq(4'b1111, 1'b0, 0);
      chk("pe_nreq",   nreq, 0);
      chk("pe_out_s2", 32'(sout[2]), 32'd0);

      // Positive saturation: 20000 + 20000.
      set_resp(4'b0011, 16'sd20000, 16'sd20000, 16'sd0, 16'sd0);
      run_seq(4'b0011, 1'b1, 0);
      chk("satp_vlist",  32'(vlist), 32'h0001);
      chk("satp_rdycyc", rdy_cyc, 10);
      chk("satp_out_s0", 32'(sout[0]), 32'd32767);
      chk("satp_out_s1", 32'(sout[1]), 32'd20000);
      chk("satp_out_s2", 32'(sout[2]), 32'd10000);

      // Negative saturation: -20000 + -20000.
      set_resp(4'b0011, -16'sd20000, -16'sd20000, 16'sd0, 16'sd0);
      run_seq(4'b0011, 1'b1, 0);
      chk("satn_out_s0", 32'(sout[0]), -32'sd32768);
      chk("satn_out_s1", 32'(sout[1]), -32'sd20000);
      chk("satn_out_s2", 32'(sout[2]), -32'sd10000);

      // Only voice 2, answer -3: shift floors toward minus infinity.
      set_resp(4'b0100, 16'sd0, 16'sd0, -16'sd3, 16'sd0);
      run_seq(4'b0100, 1'b1, 0);
      chk("v2_nreq",   nreq, 1);
      chk("v2_vlist",  32'(vlist), 32'h0002);
      chk("v2_rdycyc", rdy_cyc, 8);
      chk("v2_out_s0", 32'(sout[0]), -32'sd3);
      chk("v2_out_s1", 32'(sout[1]), -32'sd2);
      chk("v2_out_s2", 32'(sout[2]), -32'sd1);
      chk("v2_flt",    32'(flt[0]), 32'd0);

      // Voice 1 never answers: 15-cycle timeout, fault set, sequence completes.
      set_resp(4'b1001, 16'sd100, 16'sd0, 16'sd0, 16'sd100);
      run_seq(4'b1011, 1'b1, 0);
      chk("to_vlist",  32'(vlist), 32'h0007);
      chk("to_rdycyc", rdy_cyc, 26);
      chk("to_pulses", pulses, 1);
      chk("to_flt",    32'(flt[0]), 32'd1);
      chk("to_out_s0", 32'(sout[0]), 32'd200);
      chk("to_ovr_pre", 32'(ovr[0]), 32'd0);

      // Second request while voice 0 is in WAIT: dropped, overrun set.
      set_resp(4'b1111, 16'sd8000, 16'sd8000, 16'sd8000, 16'sd8000);
      run_seq(4'b1111, 1'b1, 3);
      chk("ovr_flag",   32'(ovr[2]), 32'd1);
      chk("ovr_pulses", pulses, 1);
      chk("ovr_rdycyc", rdy_cyc, 14);
      chk("ovr_out_s2", 32'(sout[2]), 32'd8000);

      // Asynchronous reset while in WAIT clears every output without a clock edge.
      voice_active = 4'b0001;
      set_resp(4'b0000, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
      @(negedge clk) gen = 1'b1;
      @(negedge clk) gen = 1'b0;
      @(negedge clk);
      chk("mid_req", 32'(lreq[2]), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_out", 32'(sout[2]), 32'd0);
      chk("mid_rst_ovr", 32'(ovr[2]),  32'd0);
      chk("mid_rst_flt", 32'(flt[2]),  32'd0);
      chk("mid_rst_req", 32'(lreq[2]), 32'd0);
      chk("mid_rst_rdy", 32'(rdy[2]),  32'd0);
      @(negedge clk) reset = 1'b0;

      set_resp(4'b1111, 16'sd8000, 16'sd8000, 16'sd8000, 16'sd8000);
      run_seq(4'b1111, 1'b1, 0);
      chk("post_vlist",  32'(vlist), 32'h001B);
      chk("post_rdycyc", rdy_cyc, 14);
      chk("post_out_s2", 32'(sout[2]), 32'd8000);
      chk("post_flt",    32'(flt[2]), 32'd0);
      chk("post_ovr",    32'(ovr[2]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
